rx_iq_gain_pack: RTL

- Consumes the four 16-bit bw20 IQ outputs (two antennas) and their valid strobe from the DDC bank interface.
- Applies a configurable digital gain: left shift of 0..3 with signed saturation.
- Packs each sample set into one 64-bit word and buffers it in a small FIFO.
- Presents the words on an AXI-Stream style master port toward the RX packet/DMA path, and counts samples dropped on overflow.

---
 rtl/rx_iq_gain_pack.sv | 114 +++++++++++
 1 files changed

// File: rtl/rx_iq_gain_pack.sv
// Gains the two-antenna bw20 IQ set with a saturating left shift, packs it to 64 bits and
// buffers it in a first-word-fall-through FIFO feeding an AXI-Stream master.
module rx_iq_gain_pack #(
  parameter int IQ_DATA_WIDTH          = 16,
  parameter int C_M00_AXIS_TDATA_WIDTH = 64,
  parameter int FIFO_ADDR_WIDTH        = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [1:0]                        gain_cfg,
  input  logic [IQ_DATA_WIDTH-1:0]          bw20_i0,
  input  logic [IQ_DATA_WIDTH-1:0]          bw20_q0,
  input  logic [IQ_DATA_WIDTH-1:0]          bw20_i1,
  input  logic [IQ_DATA_WIDTH-1:0]          bw20_q1,
  input  logic                              bw20_data_tvalid,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  output logic                              m00_axis_tvalid,
  input  logic                              m00_axis_tready,
  input  logic                              ovf_clr,
  output logic [15:0]                       ovf_cnt,
  output logic [FIFO_ADDR_WIDTH:0]          fifo_level
);

  localparam int W     = IQ_DATA_WIDTH;
  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam logic [FIFO_ADDR_WIDTH:0] LP_DEPTH = (FIFO_ADDR_WIDTH + 1)'(DEPTH);

  // Shift at W+3 bits; the top four bits must agree or the result is out of range.
  function automatic logic [W-1:0] sat_shift(input logic [W-1:0] x, input logic [1:0] sh);
    logic [W+2:0] ext;
    ext = {{3{x[W-1]}}, x} << sh;
    if (!ext[W+2] && (|ext[W+1:W-1])) begin
      sat_shift = {1'b0, {(W-1){1'b1}}};
    end else if (ext[W+2] && !(&ext[W+1:W-1])) begin
      sat_shift = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_shift = ext[W-1:0];
    end
  endfunction

  logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_stage_data;
  logic                              r_stage_valid;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_mem [DEPTH];
  logic [FIFO_ADDR_WIDTH-1:0]        r_wr_ptr;
  logic [FIFO_ADDR_WIDTH-1:0]        r_rd_ptr;
  logic [FIFO_ADDR_WIDTH:0]          r_level;
  logic [15:0]                       r_ovf_cnt;

  logic w_full;
  logic w_tvalid;
  logic w_wr;
  logic w_rd;
  logic w_drop;

  assign w_full   = (r_level == LP_DEPTH);
  assign w_tvalid = (r_level != '0);
  // Fullness is judged before the same-cycle pop, so a full FIFO never writes through.
  assign w_wr     = r_stage_valid && !w_full;
  assign w_drop   = r_stage_valid && w_full;
  assign w_rd     = w_tvalid && m00_axis_tready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stage_data  <= '0;
      r_stage_valid <= 1'b0;
    end else begin
      r_stage_valid <= bw20_data_tvalid && enable;
      if (bw20_data_tvalid && enable) begin
        r_stage_data <= {sat_shift(bw20_q1, gain_cfg), sat_shift(bw20_i1, gain_cfg),
                         sat_shift(bw20_q0, gain_cfg), sat_shift(bw20_i0, gain_cfg)};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_stage_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_ovf_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
      if (ovf_clr) begin
        r_ovf_cnt <= '0;
      end else if (w_drop && (r_ovf_cnt != 16'hFFFF)) begin
        r_ovf_cnt <= r_ovf_cnt + 16'd1;
      end
    end
  end

  // Gating by tvalid keeps tdata at zero whenever the FIFO is empty, including in reset.
  assign m00_axis_tdata  = w_tvalid ? r_mem[r_rd_ptr] : '0;
  assign m00_axis_tvalid = w_tvalid;
  assign fifo_level      = r_level;
  assign ovf_cnt         = r_ovf_cnt;

endmodule
